multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing controller for the next-generation RISC-V core. It replaces the single-cycle decoder with an FSM that drives a shared-memory datapath: PC, IR, ALUOut and data registers, one ALU, one unified instruction/data memory port. Each instruction takes 3–5 states, plus memory wait states signalled through a req/ready handshake. The block also counts retired instructions and traps on unsupported opcodes.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `opcode`  in  7: IR[6:0].
- `funct3`  in  3: IR[14:12].
- `funct7`  in  7: IR[31:25].
- `zero`  in  1: ALU zero flag.
- `mem_ready`  in  1: memory accepts or completes the current access.
- `mem_req`  out  1: memory access request.
- `mem_write`  out  1: request is a store.
- `adr_src`  out  1: memory address select. 0 = PC, 1 = ALUOut.
- `pc_write`  out  1: load the PC from the result bus.
- `ir_write`  out  1: load the IR and old-PC registers.
- `reg_write`  out  1: register-file write enable.
- `alu_src_a`  out  2: ALU A select. 00 = PC, 01 = old PC, 10 = rs1 register.
- `alu_src_b`  out  2: ALU B select. 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `result_src`  out  2: result bus select. 00 = ALUOut, 01 = data register, 10 = live ALU result.
- `imm_src`  out  3: immediate format. 000 = I, 001 = S, 010 = B, 011 = J.
- `alu_control`  out  4: ALU operation, encoded per the package.
- `illegal`  out  1: sticky trap flag.
- `state_out`  out  4: current state encoding, for debug.
- `instret`  out  INSTRET_W: count of retired instructions.

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - beq 1100011
  - jal 1101111
- Outputs are Moore (decoded from the current state), with three exceptions:
  - `pc_write` and `ir_write` in FETCH are gated by `mem_ready`.
  - `pc_write` in BEQ equals `zero`.
  - `alu_control` in EXECR and EXECI is decoded from funct fields.
- Any output not listed for a state is 0.
- States and transitions:
  - FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10. `ir_write` and `pc_write` assert when `mem_ready`. Stay in FETCH while `!mem_ready`; go to DECODE when `mem_ready`.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, `imm_src`=B, ADD (precomputes the branch target). Next state by opcode:
    - lw or sw → MEMADR
    - R-type → EXECR
    - I-ALU → EXECI
    - beq → BEQ
    - jal → JAL
    - anything else → TRAP
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, ADD, `imm_src`=I for lw / S for sw. Next: lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: `mem_req`=1, `adr_src`=1. Stay while `!mem_ready`; then → MEMWB.
  - MEMWB: `result_src`=01, `reg_write`=1. → FETCH.
  - MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Stay while `!mem_ready`; then → FETCH.
  - EXECR: `alu_src_a`=10, `alu_src_b`=00, decoded op. → ALUWB.
  - EXECI: `alu_src_a`=10, `alu_src_b`=01, `imm_src`=I, decoded op. → ALUWB.
  - ALUWB: `result_src`=00, `reg_write`=1. → FETCH.
  - BEQ: `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00, `pc_write`=`zero`. → FETCH.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, ADD, `result_src`=00, `pc_write`=1. → ALUWB (writes old PC+4 to rd).
  - TRAP: all enables 0, `illegal`=1. Terminal until reset.
- ALU decode:
  - funct3 000: ADD, or SUB when R-type and funct7[5]=1.
  - 001: SLL.
  - 010: SLT.
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1. Applies to both R-type and I-type.
  - 110: OR.
  - 111: AND.
  - 011 is unsupported: DECODE → TRAP for R-type and I-ALU.
- Non-beq branch funct3 (≠000) → TRAP.
- `instret` increments by 1 on each exit from MEMWB, ALUWB, BEQ, and MEMWRITE-with-`mem_ready`. It wraps modulo 2^INSTRET_W.

## Timing
- Reset (asynchronous, active-high): state = FETCH, `instret` = 0, `illegal` = 0.
- While `reset` is high, `mem_req`, `mem_write`, `pc_write`, `ir_write` and `reg_write` are forced to 0.
- Reset mid-access abandons the access. The first post-reset cycle is a fresh FETCH.
- Memory handshake:
  - `mem_req`, `adr_src` and `mem_write` stay stable from the first request cycle until the cycle `mem_ready` is sampled high.
  - `mem_ready` is ignored while `mem_req` is 0.
- Latency with `mem_ready` tied high:
  - beq: 3 cycles
  - sw, R-type, I-ALU, jal: 4 cycles
  - lw: 5 cycles
- Each low-`mem_ready` cycle adds 1 cycle, in FETCH, MEMREAD or MEMWRITE.

## Structure
- Package `mc_pkg`:
  - `state_t` enum (12 states, 4 bits).
  - `alu_op_t` encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000.
  - Opcode constants.
  - `imm_src`, `alu_src_a`, `alu_src_b` and `result_src` encodings.
- Sub-module `mc_alu_decoder`: combinational decoder from (opcode, funct3, funct7) to (`alu_control`, legal).
- The FSM, output decode and counter live in `multicycle_control`.

## Test plan
- add x3,x1,x2 (0x002081B3) with `mem_ready`=1: states FETCH, DECODE, EXECR, ALUWB. `reg_write` in cycle 4, `alu_control`=0001 for sub (0x402081B3). `instret` 0→1.
- lw (0x0000A183) with `mem_ready` low 2 cycles in FETCH and 3 in MEMREAD: 10 cycles total. `mem_req` and `adr_src` held stable. `reg_write` only in MEMWB.
- beq (0x00208463) with `zero`=1 vs `zero`=0: `pc_write` in BEQ is 1 vs 0. 3 cycles each.
- jal (0x008000EF): JAL `pc_write`=1, then ALUWB `reg_write`=1 with `result_src`=00.
- Opcode 0x0000007F, or R-type funct3=011: DECODE→TRAP, `illegal`=1, no enables asserted for 20 cycles. `reset` clears to FETCH.
- Assert `reset` during MEMWRITE wait: `mem_req`/`mem_write` drop immediately, state = FETCH. With INSTRET_W=4, 16 retirements wrap `instret` to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle sequencing controller.
// Imported by the ALU decoder and the top-level FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1000
    } alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // True on the last cycle of a completed instruction.
    function automatic logic retires(state_t s, logic rdy);
        return (s == MEMWB) || (s == ALUWB) || (s == BEQ) ||
               ((s == MEMWRITE) && rdy);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU-operation decode plus instruction legality check.
// The operation is meaningful only in the EXECR/EXECI states.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_control,
    output logic       legal
);

    logic    is_r;
    alu_op_t op;
    logic    unused_funct7;

    assign is_r          = (opcode == OP_R);
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        op = ALU_ADD;
        unique case (funct3)
            3'b000: op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_ADD;
            3'b100: op = ALU_XOR;
            3'b101: op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_JAL: legal = 1'b1;
            OP_R, OP_I:           legal = (funct3 != 3'b011);
            OP_BEQ:               legal = (funct3 == 3'b000);
            default:              legal = 1'b0;
        endcase
    end

    assign alu_control = op;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V sequencing FSM with memory handshake,
// retired-instruction counter and sticky illegal-opcode trap.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_src,
    output logic [3:0]           alu_control,
    output logic                 illegal,
    output logic [3:0]           state_out,
    output logic [INSTRET_W-1:0] instret
);

    state_t                 state_q, state_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic [3:0]             dec_op;
    logic                   dec_legal;
    logic                   mem_req_c, mem_write_c;
    logic                   pc_write_c, ir_write_c, reg_write_c;

    mc_alu_decoder u_alu_dec (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_op),
        .legal       (dec_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        result_src  = RES_ALUOUT;
        imm_src     = IMM_I;
        alu_control = ALU_ADD;
        illegal     = 1'b0;

        unique case (state_q)
            FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                if (!dec_legal) begin
                    state_d = TRAP;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = MEMADR;
                        OP_R:         state_d = EXECR;
                        OP_I:         state_d = EXECI;
                        OP_BEQ:       state_d = BEQ;
                        OP_JAL:       state_d = JAL;
                        default:      state_d = TRAP;
                    endcase
                end
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
                state_d   = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src  = RES_DATA;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = dec_op;
                state_d     = ALUWB;
            end
            EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                imm_src     = IMM_I;
                alu_control = dec_op;
                state_d     = ALUWB;
            end
            ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
            BEQ: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = ALU_SUB;
                pc_write_c  = zero;
                state_d     = FETCH;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            TRAP: begin
                illegal = 1'b1;
                state_d = TRAP;
            end
            default: state_d = FETCH;
        endcase
    end

    assign instret_d = instret_q
                     + INSTRET_W'(retires(state_q, mem_ready));

    // The reset state is FETCH, which would otherwise request memory.
    assign mem_req   = mem_req_c   & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign pc_write  = pc_write_c  & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign reg_write = reg_write_c & ~reset;

    assign state_out = state_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed + randomized bench for multicycle_control; expected
// per-cycle state/control traces come from a per-instruction model.
module tb_multicycle_control;
    import mc_pkg::*;

    localparam int IW = 4;

    logic          clk;
    logic          reset;
    logic          zero;
    logic          mem_ready;
    logic          mem_req, mem_write, adr_src;
    logic          pc_write, ir_write, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, result_src;
    logic [2:0]    imm_src;
    logic [3:0]    alu_control;
    logic          illegal;
    logic [3:0]    state_out;
    logic [IW-1:0] instret;
    logic [31:0]   cur_ir;
    logic          cur_z;
    logic [19:0]   ctrl_obs;

    int tests;
    int fails;
    int exp_instret;

    multicycle_control #(.INSTRET_W(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (cur_ir[6:0]),
        .funct3      (cur_ir[14:12]),
        .funct7      (cur_ir[31:25]),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal),
        .state_out   (state_out),
        .instret     (instret)
    );

    assign ctrl_obs = {mem_req, mem_write, adr_src, ir_write,
                       pc_write, reg_write, illegal, alu_src_a,
                       alu_src_b, result_src, imm_src, alu_control};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_op(logic [31:0] ir);
        logic r;
        logic f75;
        r   = (ir[6:0] == 7'h33);
        f75 = ir[30];
        case (ir[14:12])
            3'd0:    return (r && f75) ? 4'd1 : 4'd0;
            3'd1:    return 4'd6;
            3'd2:    return 4'd5;
            3'd4:    return 4'd4;
            3'd5:    return f75 ? 4'd8 : 4'd7;
            3'd6:    return 4'd3;
            3'd7:    return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [19:0] exp_ctrl(state_t s, logic rdy);
        logic       mreq, mw, adr, irw, pcw, rw, ill;
        logic [1:0] a, b, res;
        logic [2:0] imm;
        logic [3:0] alu;
        mreq = (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
        mw   = (s == MEMWRITE);
        adr  = (s == MEMREAD) || (s == MEMWRITE);
        irw  = (s == FETCH) && rdy;
        pcw  = ((s == FETCH) && rdy) || ((s == BEQ) && cur_z)
            || (s == JAL);
        rw   = (s == MEMWB) || (s == ALUWB);
        ill  = (s == TRAP);
        a = 2'd0; b = 2'd0; res = 2'd0; imm = 3'd0; alu = 4'd0;
        case (s)
            FETCH:  begin b = 2'd2; res = 2'd2; end
            DECODE: begin a = 2'd1; b = 2'd1; imm = 3'd2; end
            MEMADR: begin
                a = 2'd2; b = 2'd1;
                imm = (cur_ir[6:0] == 7'h23) ? 3'd1 : 3'd0;
            end
            MEMWB:  res = 2'd1;
            EXECR:  begin a = 2'd2; alu = model_op(cur_ir); end
            EXECI:  begin a = 2'd2; b = 2'd1; alu = model_op(cur_ir); end
            BEQ:    begin a = 2'd2; alu = 4'd1; end
            JAL:    begin a = 2'd1; b = 2'd2; end
            default: ;
        endcase
        return {mreq, mw, adr, irw, pcw, rw, ill, a, b, res, imm, alu};
    endfunction

    task automatic step(input state_t s, input logic rdy);
        mem_ready = rdy;
        zero      = cur_z;
        #1;
        chk("state", 32'(state_out), 32'(s));
        chk("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(s, rdy)));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", 32'(state_out), 32'(FETCH));
        chk("rst_en", 32'({mem_req, mem_write, pc_write, ir_write,
                           reg_write}), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        exp_instret = 0;
    endtask

    task automatic run_instr(input logic [31:0] ir, input int wf,
                             input int wm, input logic z);
        state_t     sq[$];
        logic       rq[$];
        logic [2:0] f3;
        cur_ir = ir;
        cur_z  = z;
        f3     = ir[14:12];
        chk("instret", 32'(instret), 32'(exp_instret));
        for (int i = 0; i < wf; i++) begin
            sq.push_back(FETCH); rq.push_back(1'b0);
        end
        sq.push_back(FETCH);  rq.push_back(1'b1);
        sq.push_back(DECODE); rq.push_back(1'($urandom_range(0, 1)));
        case (ir[6:0])
            7'h03: begin
                sq.push_back(MEMADR); rq.push_back(1'b1);
                for (int i = 0; i < wm; i++) begin
                    sq.push_back(MEMREAD); rq.push_back(1'b0);
                end
                sq.push_back(MEMREAD); rq.push_back(1'b1);
                sq.push_back(MEMWB);   rq.push_back(1'b0);
            end
            7'h23: begin
                sq.push_back(MEMADR); rq.push_back(1'b0);
                for (int i = 0; i < wm; i++) begin
                    sq.push_back(MEMWRITE); rq.push_back(1'b0);
                end
                sq.push_back(MEMWRITE); rq.push_back(1'b1);
            end
            7'h33, 7'h13: begin
                if (f3 == 3'd3) begin
                    sq.push_back(TRAP); rq.push_back(1'b1);
                end else begin
                    sq.push_back(ir[6:0] == 7'h33 ? EXECR : EXECI);
                    rq.push_back(1'b1);
                    sq.push_back(ALUWB); rq.push_back(1'b1);
                end
            end
            7'h63: begin
                sq.push_back(f3 == 3'd0 ? BEQ : TRAP);
                rq.push_back(1'b1);
            end
            7'h6F: begin
                sq.push_back(JAL);   rq.push_back(1'b1);
                sq.push_back(ALUWB); rq.push_back(1'b0);
            end
            default: begin
                sq.push_back(TRAP); rq.push_back(1'b1);
            end
        endcase
        for (int i = 0; i < sq.size(); i++) step(sq[i], rq[i]);
        if (sq[sq.size()-1] != TRAP)
            exp_instret = (exp_instret + 1) % (1 << IW);
    endtask

    initial begin
        logic [31:0] ir;
        logic [2:0]  f3;
        int          k;
        tests = 0; fails = 0; exp_instret = 0;
        cur_ir = 32'h0; cur_z = 1'b0; zero = 1'b0;
        mem_ready = 1'b0; reset = 1'b1;
        do_reset();

        run_instr(32'h002081B3, 0, 0, 1'b0);
        run_instr(32'h402081B3, 0, 0, 1'b0);
        run_instr(32'h0000A183, 2, 3, 1'b0);
        run_instr(32'h00208463, 0, 0, 1'b1);
        run_instr(32'h00208463, 0, 0, 1'b0);
        run_instr(32'h008000EF, 0, 0, 1'b0);
        run_instr(32'h0020A023, 1, 2, 1'b0);
        run_instr(32'h4050D193, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ir = $urandom;
            k  = $urandom_range(0, 5);
            f3 = 3'($urandom_range(0, 7));
            if (f3 == 3'd3) f3 = 3'd0;
            case (k)
                0: ir[6:0] = 7'h03;
                1: ir[6:0] = 7'h23;
                2: begin ir[6:0] = 7'h33; ir[14:12] = f3; end
                3: begin ir[6:0] = 7'h13; ir[14:12] = f3; end
                4: begin ir[6:0] = 7'h63; ir[14:12] = 3'd0; end
                default: ir[6:0] = 7'h6F;
            endcase
            run_instr(ir, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end

        do_reset();
        for (int n = 0; n < 16; n++)
            run_instr(32'h00208463, 0, 0, 1'($urandom_range(0, 1)));
        chk("wrap", 32'(instret), 32'd0);

        run_instr(32'h002081B3, 0, 0, 1'b0);
        cur_ir = 32'h0020A023;
        step(FETCH, 1'b1);
        step(DECODE, 1'b0);
        step(MEMADR, 1'b1);
        step(MEMWRITE, 1'b0);
        step(MEMWRITE, 1'b0);
        do_reset();
        run_instr(32'h002081B3, 0, 0, 1'b0);

        run_instr(32'h0000007F, 0, 0, 1'b0);
        for (int n = 0; n < 20; n++) step(TRAP, 1'($urandom_range(0, 1)));
        do_reset();
        run_instr(32'h0000A183, 0, 0, 1'b0);

        run_instr(32'h0020B1B3, 1, 0, 1'b0);
        for (int n = 0; n < 20; n++) step(TRAP, 1'($urandom_range(0, 1)));
        do_reset();
        run_instr(32'h00208463, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
